// File: rtl/axi_burst_counter_master.sv
// AXI4 write master that fills a memory region with a counter sequence,
// split into INCR bursts of at most MAX_BURST_LEN beats that never cross a 4 KB page.
module axi_burst_counter_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr_i,
  input  logic [31:0]             cfg_bytes_i,
  input  logic [DATA_WIDTH-1:0]   cfg_init_i,
  input  logic [DATA_WIDTH-1:0]   cfg_incr_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [1:0]              status_o,
  output logic [ID_WIDTH-1:0]     awid_o,
  output logic [ADDR_WIDTH-1:0]   awaddr_o,
  output logic [7:0]              awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] wstrb_o,
  output logic                    wlast_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_WIDTH-1:0]     bid_i,
  input  logic [1:0]              bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  output logic [2:0]              dbg_state_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t                state;
  logic [31:0]           rem_q;
  logic [DATA_WIDTH-1:0] incr_q;
  logic [DATA_WIDTH-1:0] cnt_q;
  logic [7:0]            beat_q;
  logic [8:0]            len_q;
  logic [1:0]            status_q;
  logic [ID_WIDTH-1:0]   awid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;

  // Beats that fit: remaining work, burst cap, and room left in the current 4 KB page.
  function automatic logic [8:0] calc_len(input logic [11:0] off, input logic [31:0] rem);
    logic [31:0] page;
    logic [31:0] lim;
    page = (32'd4096 - 32'(off)) >> SIZE;
    lim  = rem;
    if (lim > 32'(MAX_BURST_LEN)) lim = 32'(MAX_BURST_LEN);
    if (lim > page) lim = page;
    return 9'(lim);
  endfunction

  logic [ADDR_WIDTH-1:0] start_addr;
  logic [31:0]           start_beats;
  logic [8:0]            start_len;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0]           next_rem;
  logic [8:0]            next_len;

  assign start_addr  = cfg_addr_i & ~ADDR_WIDTH'(BYTES - 1);
  assign start_beats = cfg_bytes_i >> SIZE;
  assign start_len   = calc_len(start_addr[11:0], start_beats);
  assign next_addr   = awaddr_q + (ADDR_WIDTH'(len_q) << SIZE);
  assign next_rem    = rem_q - 32'(len_q);
  assign next_len    = calc_len(next_addr[11:0], next_rem);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state    <= IDLE;
      rem_q    <= '0;
      incr_q   <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      status_q <= '0;
      awid_q   <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          rem_q    <= start_beats;
          incr_q   <= cfg_incr_i;
          cnt_q    <= cfg_init_i;
          status_q <= 2'b00;
          if (start_beats == 32'd0) begin
            state <= DONE;
          end else begin
            awaddr_q <= start_addr;
            awlen_q  <= 8'(start_len - 9'd1);
            len_q    <= start_len;
            beat_q   <= '0;
            state    <= ADDR;
          end
        end
        ADDR: if (awready_i) state <= DATA;
        DATA: if (wready_i) begin
          cnt_q  <= cnt_q + incr_q;
          beat_q <= beat_q + 8'd1;
          if (beat_q == awlen_q) state <= RESP;
        end
        RESP: if (bvalid_i) begin
          status_q <= bresp_i;
          rem_q    <= next_rem;
          // Any non-OKAY response stops the transfer without issuing further bursts.
          if (bresp_i != 2'b00 || next_rem == 32'd0) begin
            state <= DONE;
          end else begin
            awaddr_q <= next_addr;
            awlen_q  <= 8'(next_len - 9'd1);
            len_q    <= next_len;
            beat_q   <= '0;
            state    <= ADDR;
          end
        end
        DONE: begin
          awid_q <= awid_q + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every channel uses AXI valid/ready: a transfer happens on a rising clk edge where
  // both are high; once raised, valid and its payload hold until that edge.
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign awvalid_o   = (state == ADDR);
  assign wvalid_o    = (state == DATA);
  assign bready_o    = (state == RESP);
  assign wlast_o     = (beat_q == awlen_q) && wvalid_o;
  assign wdata_o     = cnt_q;
  assign wstrb_o     = '1;
  assign awsize_o    = 3'(SIZE);
  assign awburst_o   = 2'b01;
  assign awid_o      = awid_q;
  assign awaddr_o    = awaddr_q;
  assign awlen_o     = awlen_q;
  assign status_o    = status_q;
  assign dbg_state_o = state;

  wire unused_bid = ^bid_i;

endmodule

// File: tb/tb_axi_burst_counter_master.sv
// Randomized bench for axi_burst_counter_master: a transfer-level model fills
// expected queues, an AXI slave responds, and a monitor pops and compares.
module tb_axi_burst_counter_master;

  logic        clk;
  logic        areset;
  logic [31:0] cfg_addr_i, cfg_bytes_i, cfg_init_i, cfg_incr_i;
  logic        start_i;
  logic        busy_o, done_o;
  logic [1:0]  status_o;
  logic [3:0]  awid_o;
  logic [31:0] awaddr_o;
  logic [7:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o, wvalid_o;
  logic        wready_i = 1'b0;
  logic [3:0]  bid_i = '0;
  logic [1:0]  bresp_i = '0;
  logic        bvalid_i = 1'b0;
  logic        bready_o;
  logic [2:0]  dbg_state_o;

  axi_burst_counter_master dut (
    .clk(clk), .areset(areset),
    .cfg_addr_i(cfg_addr_i), .cfg_bytes_i(cfg_bytes_i),
    .cfg_init_i(cfg_init_i), .cfg_incr_i(cfg_incr_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .status_o(status_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
    .bready_o(bready_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // ---------------- scoreboard ----------------
  logic [43:0] exp_aw_q[$];   // {awid, awaddr, awlen}
  logic [32:0] exp_w_q[$];    // {wlast, wdata}
  logic [1:0]  exp_done_q[$]; // final status
  logic [1:0]  resp_q[$];     // BRESP the slave returns per burst

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] exp_id = '0;
  int aw_delay = 0;
  int wmode = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic flag_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cycle);
  endtask

  // ---------------- AXI slave ----------------
  int aw_wait = 0;
  bit b_pend = 0;
  bit w_tog = 0;
  bit b_hs, wl_hs;
  always begin
    @(negedge clk);
    b_hs  = bvalid_i && bready_o;
    wl_hs = wvalid_o && wready_i && wlast_o;
    @(posedge clk);
    #1;
    if (!areset) begin
      awready_i = 0; wready_i = 0; bvalid_i = 0;
      aw_wait = 0; b_pend = 0; w_tog = 0;
    end else begin
      if (b_hs) bvalid_i = 0;
      if (wl_hs) b_pend = 1;
      if (b_pend && !bvalid_i && $urandom_range(0, 2) != 0) begin
        bvalid_i = 1;
        bresp_i  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
        bid_i    = 4'($urandom);
        b_pend   = 0;
      end
      if (awvalid_o) begin
        awready_i = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        awready_i = 0;
        aw_wait = 0;
      end
      case (wmode)
        0: wready_i = 1'($urandom_range(0, 1));
        1: wready_i = 1;
        default: if (wvalid_o) begin
          wready_i = !w_tog;
          w_tog = !w_tog;
        end else begin
          wready_i = 0;
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit prev_aw_stall = 0, prev_w_stall = 0, saw_b = 0;
  logic [31:0] prev_awaddr, prev_wdata;
  logic [7:0]  prev_awlen;
  logic        prev_wlast;
  int          b_cycle = 0;
  always @(negedge clk) begin
    if (!areset) begin
      prev_aw_stall = 0; prev_w_stall = 0; saw_b = 0;
    end else begin
      if (prev_aw_stall) begin
        chk("aw_hold_valid", awvalid_o, 1);
        chk("aw_hold_addr", awaddr_o, prev_awaddr);
        chk("aw_hold_len", awlen_o, prev_awlen);
      end
      if (prev_w_stall) begin
        chk("w_hold_valid", wvalid_o, 1);
        chk("w_hold_data", wdata_o, prev_wdata);
        chk("w_hold_last", wlast_o, prev_wlast);
      end
      if (awvalid_o && awready_i) begin
        if (exp_aw_q.size() == 0) flag_fail("aw_unexpected");
        else chk("aw_beat", {awid_o, awaddr_o, awlen_o}, exp_aw_q.pop_front());
      end
      if (wvalid_o && wready_i) begin
        if (exp_w_q.size() == 0) flag_fail("w_unexpected");
        else chk("w_beat", {wlast_o, wdata_o}, exp_w_q.pop_front());
      end
      if (bvalid_i && bready_o) begin
        saw_b = 1;
        b_cycle = cycle;
      end
      if (done_o) begin
        if (saw_b) chk("done_after_b", cycle, b_cycle + 1);
        saw_b = 0;
        chk("done_busy", busy_o, 1);
        if (exp_done_q.size() == 0) flag_fail("done_unexpected");
        else chk("done_status", status_o, exp_done_q.pop_front());
      end
      prev_aw_stall = awvalid_o && !awready_i;
      prev_awaddr = awaddr_o;
      prev_awlen = awlen_o;
      prev_w_stall = wvalid_o && !wready_i;
      prev_wdata = wdata_o;
      prev_wlast = wlast_o;
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic model(input logic [31:0] addr, input logic [31:0] bytes,
                       input logic [31:0] init, input logic [31:0] incr,
                       input int err_burst, output logic [1:0] status);
    logic [31:0] a, cnt;
    longint rem, page_left, len;
    int k;
    a = addr & ~32'd3;
    rem = bytes / 4;
    cnt = init;
    k = 0;
    status = 2'b00;
    while (rem > 0) begin
      page_left = (4096 - (a % 4096)) / 4;
      len = rem;
      if (len > 16) len = 16;
      if (len > page_left) len = page_left;
      exp_aw_q.push_back({exp_id, a, 8'(len - 1)});
      for (int i = 0; i < len; i++) begin
        exp_w_q.push_back({(i == len - 1), cnt});
        cnt = cnt + incr;
      end
      status = (k == err_burst) ? 2'b10 : 2'b00;
      resp_q.push_back(status);
      if (status != 2'b00) break;
      a = a + 32'(len * 4);
      rem = rem - len;
      k++;
    end
    exp_done_q.push_back(status);
  endtask

  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] bytes,
                          input logic [31:0] init, input logic [31:0] incr,
                          input int err_burst, input int aw_d, input int wm,
                          input bit coincide, input bit busy_start);
    logic [1:0] st;
    bit beats_nz;
    int c;
    beats_nz = (bytes / 4) != 0;
    aw_delay = aw_d;
    wmode = wm;
    for (c = 0; c < 50 && busy_o; c++) @(negedge clk);
    model(addr, bytes, init, incr, err_burst, st);
    @(posedge clk); #1;
    cfg_addr_i = addr; cfg_bytes_i = bytes; cfg_init_i = init; cfg_incr_i = incr;
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    @(negedge clk);
    chk("start_busy", busy_o, 1);
    chk("start_awvalid", awvalid_o, beats_nz);
    chk("start_done", done_o, !beats_nz);
    chk("start_status_clear", status_o, 0);
    if (busy_start && beats_nz) begin
      // A second start while busy must change nothing.
      cfg_addr_i = 32'h0000_8000; cfg_bytes_i = 32'd64; cfg_init_i = 32'h55; cfg_incr_i = 32'd3;
      start_i = 1;
      @(posedge clk); #1;
      start_i = 0;
    end
    for (c = 0; c < 3000; c++) begin
      @(negedge clk); #2;
      if (coincide && done_o) begin
        cfg_addr_i = 32'h0000_9000; cfg_bytes_i = 32'd16;
        start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
      end
      if (exp_done_q.size() == 0 && !busy_o) break;
    end
    if (c == 3000) flag_fail("xfer_timeout");
    repeat (3) @(negedge clk);
    chk("idle_busy", busy_o, 0);
    chk("status_hold", status_o, st);
    chk("aw_drained", exp_aw_q.size(), 0);
    chk("w_drained", exp_w_q.size(), 0);
    exp_id = exp_id + 1'b1;
  endtask

  task automatic flush();
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_done_q.delete();
    resp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra;
    int c;
    areset = 0; start_i = 0;
    cfg_addr_i = 0; cfg_bytes_i = 0; cfg_init_i = 0; cfg_incr_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_bready", bready_o, 0);
    chk("rst_awaddr", awaddr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_awsize", awsize_o, 3'd2);
    chk("rst_awburst", awburst_o, 2'b01);
    chk("rst_wstrb", wstrb_o, 4'hF);
    @(negedge clk);
    areset = 1;

    run_xfer(32'h1000, 32,  0, 1, -1, 0, 1, 1, 0);
    run_xfer(32'h1000, 160, 0, 1, -1, 1, 0, 0, 1);
    run_xfer(32'h0FF8, 32,  0, 1, -1, 0, 0, 0, 0);
    run_xfer(32'h2000, 16,  32'hFFFF_FFFE, 1, -1, 3, 2, 0, 0);
    run_xfer(32'h3000, 128, 32'h10, 2, 0, 0, 0, 0, 0);
    run_xfer(32'h4000, 3,   0, 1, -1, 0, 1, 0, 0);
    run_xfer(32'h4002, 20,  7, 5, -1, 0, 1, 0, 0);

    for (int i = 0; i < 25; i++) begin
      ra = 32'h0001_0000 + 32'($urandom_range(0, 3)) * 32'd4096;
      if ($urandom_range(0, 1) != 0) ra = ra + 32'd4096 - 32'd4 * 32'($urandom_range(1, 20));
      else ra = ra + 32'd4 * 32'($urandom_range(0, 1023));
      ra = ra + 32'($urandom_range(0, 3));
      run_xfer(ra, 32'($urandom_range(0, 400)), $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
               $urandom_range(0, 3), $urandom_range(0, 2), 0, 0);
    end

    // Asynchronous reset while data beats are flowing.
    aw_delay = 0;
    wmode = 2;
    model(32'h5000, 64, 32'hA0, 1, -1, ra[1:0]);
    @(posedge clk); #1;
    cfg_addr_i = 32'h5000; cfg_bytes_i = 64; cfg_init_i = 32'hA0; cfg_incr_i = 1;
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    for (c = 0; c < 100 && !wvalid_o; c++) @(negedge clk);
    if (c == 100) flag_fail("reset_wait_wvalid");
    @(negedge clk); #2;
    areset = 0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_wvalid", wvalid_o, 0);
    chk("mid_rst_wlast", wlast_o, 0);
    chk("mid_rst_awvalid", awvalid_o, 0);
    chk("mid_rst_bready", bready_o, 0);
    chk("mid_rst_wdata", wdata_o, 0);
    chk("mid_rst_awaddr", awaddr_o, 0);
    chk("mid_rst_awid", awid_o, 0);
    chk("mid_rst_state", dbg_state_o, 0);
    flush();
    exp_id = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1;
    run_xfer(32'h6000, 48, 32'h100, 32'h10, -1, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
